// File: rtl/prbs_pkg.sv
// Shared types and default polynomial/seed for the lane PRBS generator/checker.
package prbs_pkg;
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  localparam logic [31:0] DEF_POLY = 32'hA300_0000;
  localparam logic [31:0] DEF_SEED = 32'h0000_0001;
endpackage

// File: rtl/lfsr_adv.sv
// Combinational DATA_W-step advance of a Fibonacci LFSR; output bit i is step i's feedback.
module lfsr_adv #(
  parameter int                LFSR_W = 32,
  parameter logic [LFSR_W-1:0] POLY   = '1,
  parameter int                DATA_W = 8
) (
  input  logic [LFSR_W-1:0] state_i,
  output logic [LFSR_W-1:0] state_o,
  output logic [DATA_W-1:0] bits_o
);
  logic [LFSR_W-1:0] s;
  logic              f;

  always_comb begin
    s      = state_i;
    f      = 1'b0;
    bits_o = '0;
    for (int i = 0; i < DATA_W; i++) begin
      f         = ^(s & POLY);
      bits_o[i] = f;
      s         = {s[LFSR_W-2:0], f};
    end
    state_o = s;
  end
endmodule

// File: rtl/prbs_gen_chk.sv
// Per-lane PRBS generator plus self-synchronising checker with lock tracking and
// a saturating bit-error counter.
module prbs_gen_chk
  import prbs_pkg::*;
#(
  parameter int                LFSR_W     = 32,
  parameter logic [LFSR_W-1:0] POLY       = LFSR_W'(DEF_POLY),
  parameter logic [LFSR_W-1:0] SEED       = LFSR_W'(DEF_SEED),
  parameter int                DATA_W     = 8,
  parameter int                LOCK_CNT   = 4,
  parameter int                UNLOCK_CNT = 3,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_val,
  input  logic              gen_en,
  output logic [DATA_W-1:0] gen_data,
  output logic              gen_valid,
  input  logic              chk_valid,
  input  logic [DATA_W-1:0] chk_data,
  output logic [1:0]        chk_state,
  output logic              chk_locked,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              err_cnt_clr
);
  localparam int HUNT_BEATS = (LFSR_W + DATA_W - 1) / DATA_W;
  localparam int CMAX0      = (HUNT_BEATS > LOCK_CNT) ? HUNT_BEATS : LOCK_CNT;
  localparam int CMAX       = (CMAX0 > UNLOCK_CNT) ? CMAX0 : UNLOCK_CNT;
  localparam int CW         = $clog2(CMAX + 1);
  localparam int PC_W       = 7;
  localparam int SW         = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------- generator ----------------
  logic [LFSR_W-1:0] gen_lfsr_q, gen_nxt;
  logic [DATA_W-1:0] gen_data_q, gen_bits;
  logic              gen_valid_q;

  lfsr_adv #(.LFSR_W(LFSR_W), .POLY(POLY), .DATA_W(DATA_W)) u_gen_adv (
    .state_i(gen_lfsr_q), .state_o(gen_nxt), .bits_o(gen_bits)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen_lfsr_q  <= SEED;
      gen_data_q  <= '0;
      gen_valid_q <= 1'b0;
    end else begin
      gen_valid_q <= 1'b0;
      if (seed_load) begin
        gen_lfsr_q <= (seed_val == '0) ? SEED : seed_val;
      end else if (gen_en) begin
        gen_lfsr_q  <= gen_nxt;
        gen_data_q  <= gen_bits;
        gen_valid_q <= 1'b1;
      end
    end
  end

  assign gen_data  = gen_data_q;
  assign gen_valid = gen_valid_q;

  // ---------------- checker ----------------
  chk_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LFSR_W-1:0] chk_lfsr_q, chk_lfsr_d, chk_nxt, hunt_s;
  logic [DATA_W-1:0] chk_exp, diff;
  logic [CNT_W-1:0]  err_q, err_d, err_sat;
  logic [PC_W-1:0]   pc;
  logic [SW-1:0]     sum;
  logic              locked_q;

  lfsr_adv #(.LFSR_W(LFSR_W), .POLY(POLY), .DATA_W(DATA_W)) u_chk_adv (
    .state_i(chk_lfsr_q), .state_o(chk_nxt), .bits_o(chk_exp)
  );

  // HUNT loads the received bits straight into the state, earliest first
  always_comb begin
    hunt_s = chk_lfsr_q;
    for (int i = 0; i < DATA_W; i++) hunt_s = {hunt_s[LFSR_W-2:0], chk_data[i]};
  end

  always_comb begin
    diff = chk_data ^ chk_exp;
    pc   = '0;
    for (int i = 0; i < DATA_W; i++) pc = pc + PC_W'(diff[i]);
    sum     = SW'(err_q) + SW'(pc);
    err_sat = (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    chk_lfsr_d = chk_lfsr_q;
    err_d      = err_q;
    if (chk_valid) begin
      unique case (state_q)
        HUNT: begin
          chk_lfsr_d = hunt_s;
          if (int'(cnt_q) == HUNT_BEATS - 1) begin
            cnt_d = '0;
            if (hunt_s != '0) state_d = VERIFY;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        VERIFY: begin
          chk_lfsr_d = chk_nxt;
          if (diff != '0) begin
            state_d = HUNT;
            cnt_d   = '0;
          end else if (int'(cnt_q) == LOCK_CNT - 1) begin
            state_d = LOCKED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        LOCKED: begin
          chk_lfsr_d = chk_nxt;
          err_d      = err_sat;
          if (diff == '0) begin
            cnt_d = '0;
          end else if (int'(cnt_q) == UNLOCK_CNT - 1) begin
            state_d = HUNT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = HUNT;
          cnt_d   = '0;
        end
      endcase
    end
    // clear wins: the coincident beat's errors are dropped
    if (err_cnt_clr) err_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HUNT;
      cnt_q      <= '0;
      chk_lfsr_q <= '0;
      err_q      <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      chk_lfsr_q <= chk_lfsr_d;
      err_q      <= err_d;
      locked_q   <= (state_d == LOCKED);
    end
  end

  assign chk_state  = state_q;
  assign chk_locked = locked_q;
  assign err_cnt    = err_q;
endmodule

// File: tb/tb_prbs_gen_chk.sv
// Directed bench: generator sequence, loopback lock, error injection, saturation,
// async reset and valid gaps.
module tb_prbs_gen_chk;
  import prbs_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DATA_W=1 instance
  logic        w1_seed_load = 1'b0, w1_gen_en = 1'b0;
  logic [31:0] w1_seed_val  = '0;
  logic [0:0]  w1_gen_data, w1_chk_data;
  logic        w1_gen_valid, w1_locked;
  logic [1:0]  w1_state;
  logic [15:0] w1_err;
  assign w1_chk_data = 1'b0;

  // DATA_W=8, CNT_W=4 instance, loopback through an error-injection mask
  logic        seed_load = 1'b0, gen_en = 1'b0, err_cnt_clr = 1'b0, loop_en = 1'b0;
  logic [31:0] seed_val  = '0;
  logic [7:0]  gen_data, chk_data;
  logic [7:0]  inj = '0;
  logic        gen_valid, chk_valid, chk_locked;
  logic [1:0]  chk_state;
  logic [3:0]  err_cnt;
  assign chk_data  = gen_data ^ inj;
  assign chk_valid = gen_valid & loop_en;

  prbs_gen_chk #(.DATA_W(1)) u_w1 (
    .clk(clk), .rst(rst), .seed_load(w1_seed_load), .seed_val(w1_seed_val),
    .gen_en(w1_gen_en), .gen_data(w1_gen_data), .gen_valid(w1_gen_valid),
    .chk_valid(1'b0), .chk_data(w1_chk_data), .chk_state(w1_state),
    .chk_locked(w1_locked), .err_cnt(w1_err), .err_cnt_clr(1'b0)
  );

  prbs_gen_chk #(.DATA_W(8), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_val(seed_val),
    .gen_en(gen_en), .gen_data(gen_data), .gen_valid(gen_valid),
    .chk_valid(chk_valid), .chk_data(chk_data), .chk_state(chk_state),
    .chk_locked(chk_locked), .err_cnt(err_cnt), .err_cnt_clr(err_cnt_clr)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // first four 8-bit beats from SEED=1 with POLY=A300_0000
  logic [7:0] exp4 [4];
  initial begin
    exp4[0] = 8'h00; exp4[1] = 8'h00; exp4[2] = 8'h00; exp4[3] = 8'hA3;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int c;
    #23;
    chk_eq("rst_gen_data", gen_data, 0);
    chk_eq("rst_gen_valid", gen_valid, 0);
    chk_eq("rst_state", chk_state, HUNT);
    chk_eq("rst_locked", chk_locked, 0);
    chk_eq("rst_err", err_cnt, 0);
    chk_eq("rst_w1_data", w1_gen_data, 0);
    rst = 1'b0;

    // DATA_W=1: 24 zeros then a one
    w1_gen_en = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      chk_eq($sformatf("w1_beat%0d", k), w1_gen_data, (k == 25) ? 1 : 0);
    end
    w1_gen_en = 1'b0;

    // wide beats, then zero-seed load restarts the sequence
    gen_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_eq($sformatf("wide_beat%0d", i), gen_data, exp4[i]);
      chk_eq("wide_valid", gen_valid, 1);
    end
    gen_en = 1'b0; seed_load = 1'b1; seed_val = '0;
    tick();
    chk_eq("load_valid", gen_valid, 0);
    chk_eq("load_hold", gen_data, 8'hA3);
    seed_load = 1'b0; gen_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_eq($sformatf("reload_beat%0d", i), gen_data, exp4[i]);
    end

    // loopback lock
    gen_en = 1'b0; seed_load = 1'b1;
    tick();
    seed_load = 1'b0; loop_en = 1'b1; gen_en = 1'b1;
    tick();
    for (int b = 1; b <= 8; b++) begin
      tick();
      chk_eq($sformatf("lock_state_b%0d", b), chk_state,
             (b < 4) ? HUNT : (b < 8) ? VERIFY : LOCKED);
      chk_eq($sformatf("lock_locked_b%0d", b), chk_locked, (b == 8) ? 1 : 0);
    end
    chk_eq("lock_err", err_cnt, 0);

    // two flipped bits in one beat
    inj = 8'h03;
    tick();
    chk_eq("inj2_err", err_cnt, 2);
    chk_eq("inj2_state", chk_state, LOCKED);
    inj = 8'h00;
    tick();
    chk_eq("inj2_clean_err", err_cnt, 2);

    // three corrupted beats drop lock
    inj = 8'h01;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_eq($sformatf("unlock_err%0d", i), err_cnt, 2 + i);
      chk_eq($sformatf("unlock_state%0d", i), chk_state, (i < 3) ? LOCKED : HUNT);
    end
    chk_eq("unlock_locked", chk_locked, 0);
    inj = 8'h00;
    for (int b = 1; b <= 8; b++) begin
      tick();
      if (b == 7) chk_eq("relock_b7", chk_state, VERIFY);
    end
    chk_eq("relock_locked", chk_locked, 1);
    chk_eq("relock_err", err_cnt, 5);

    // saturation and clear
    err_cnt_clr = 1'b1;
    tick();
    err_cnt_clr = 1'b0;
    chk_eq("clr_err", err_cnt, 0);
    for (int i = 0; i < 20; i++) begin
      inj = 8'h01; tick();
      inj = 8'h00; tick();
    end
    chk_eq("sat_err", err_cnt, 15);
    chk_eq("sat_locked", chk_locked, 1);
    err_cnt_clr = 1'b1; inj = 8'h01;
    tick();
    chk_eq("clr_wins", err_cnt, 0);
    err_cnt_clr = 1'b0; inj = 8'h00;
    tick();
    chk_eq("clr_after", err_cnt, 0);
    chk_eq("clr_locked", chk_locked, 1);

    // get into VERIFY with a non-zero count, then reset asynchronously
    inj = 8'h01;
    repeat (3) tick();
    inj = 8'h00;
    repeat (5) tick();
    chk_eq("pre_rst_state", chk_state, VERIFY);
    chk_eq("pre_rst_err", err_cnt, 3);
    #2 rst = 1'b1;
    #1;
    chk_eq("arst_state", chk_state, HUNT);
    chk_eq("arst_locked", chk_locked, 0);
    chk_eq("arst_err", err_cnt, 0);
    chk_eq("arst_gen_valid", gen_valid, 0);
    chk_eq("arst_gen_data", gen_data, 0);
    tick(); tick();
    rst = 1'b0;

    // restart from SEED with a 3-cycle valid gap during HUNT
    gen_en = 1'b1;
    tick();
    chk_eq("gap_beat0", gen_data, exp4[0]);
    c = 0;
    while (!chk_locked && c < 40) begin
      c++;
      gen_en = !(c >= 3 && c <= 5);
      tick();
      if (c == 1 || c == 2) chk_eq($sformatf("gap_beat%0d", c), gen_data, exp4[c]);
      if (c == 6) begin
        chk_eq("gap_beat3", gen_data, exp4[3]);
        chk_eq("gap_hunt", chk_state, HUNT);
      end
    end
    chk_eq("gap_lock_lat", c, 11);
    chk_eq("gap_err", err_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/prbs_gen_chk.md
# prbs_gen_chk

- Parametrised PRBS generator and self-synchronising PRBS checker for PCIe PHY lane test and bring-up.
- Generator: Fibonacci LFSR of configurable length and polynomial that emits DATA_W bits per clock. It supports runtime seed load and zero-seed protection.
- Checker: locks onto a received PRBS stream, verifies it, and tracks lock state. It counts bit errors in a saturating counter.
- One instance per lane sits between the PHY datapath and the lane test/status logic.

## Interface
- LFSR_W, 32: LFSR length in bits, 8..64.
- POLY, 32'hA300_0000: tap mask, LFSR_W bits; bit k set means state bit k feeds back.
- SEED, 32'h0000_0001: reset seed; also the fallback when an all-zero seed is loaded; must be non-zero.
- DATA_W, 8: bits generated/checked per clock, 1..64.
- LOCK_CNT, 4: consecutive clean beats in VERIFY needed to reach LOCKED.
- UNLOCK_CNT, 3: consecutive erroneous beats in LOCKED that force HUNT.
- CNT_W, 16: error counter width.
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- seed_load  in  1  load seed_val into generator LFSR.
- seed_val  in  LFSR_W  runtime seed.
- gen_en  in  1  advance generator one beat.
- gen_data  out  DATA_W  generated bits; bit 0 is the earliest.
- gen_valid  out  1  gen_data updated this cycle.
- chk_valid  in  1  chk_data beat valid.
- chk_data  in  DATA_W  received bits; bit 0 is the earliest.
- chk_state  out  2  HUNT=0, VERIFY=1, LOCKED=2.
- chk_locked  out  1  chk_state==LOCKED.
- err_cnt  out  CNT_W  saturating bit-error count.
- err_cnt_clr  in  1  synchronous clear of err_cnt.

## Operation
- **Single step** from state s:
  - f = ^(s & POLY).
  - s' = {s[LFSR_W-2:0], f}.
  - The output bit of the step is f.
- **Beat:** DATA_W successive steps; output bit i is the f of step i.
- **Generator:**
  - seed_load has priority over gen_en. On seed_load the state becomes seed_val, or SEED if seed_val==0. No output is produced and gen_valid=0 that cycle.
  - gen_en with no seed_load: gen_data gets the next beat, the state advances DATA_W steps, and gen_valid=1.
  - gen_en=0: gen_data holds and gen_valid=0.
- **Checker:** processes only cycles with chk_valid=1; all other cycles hold.
  - **HUNT:**
    - Each received bit b is shifted in, earliest first: s = {s[LFSR_W-2:0], b}.
    - A beat counter counts ceil(LFSR_W/DATA_W) beats.
    - When that count is reached, go to VERIFY, unless the resulting state is all-zero; then stay in HUNT with the counter restarted.
  - **VERIFY:**
    - Compare chk_data against the expected beat from the checker LFSR, which advances on its own state, not on the received data.
    - Any mismatch: go to HUNT.
    - LOCK_CNT consecutive clean beats: go to LOCKED.
    - err_cnt is not updated in VERIFY.
  - **LOCKED:**
    - err_cnt += popcount(chk_data ^ expected), saturating at all-ones.
    - UNLOCK_CNT consecutive beats with errors: go to HUNT. A clean beat resets this run counter.
- **err_cnt_clr:** wins over a same-cycle increment; that beat's errors are dropped.
- **Reset values:**
  - Generator LFSR = SEED, gen_data=0, gen_valid=0.
  - Checker LFSR=0, chk_state=HUNT, chk_locked=0, err_cnt=0.
  - All internal counters 0.
- **Reset mid-operation:** returns everything to the reset values immediately (asynchronous assertion); no partial beat survives.

## Timing
- All outputs are registered.
- gen_data/gen_valid appear 1 cycle after the gen_en sample.
- chk_state/chk_locked/err_cnt reflect the beat sampled on the same edge, i.e. they are visible the cycle after chk_valid.
- Lock latency from the first valid beat, with no errors: ceil(LFSR_W/DATA_W)+LOCK_CNT valid beats.
- No back-pressure: the checker accepts every valid beat, and the generator never stalls except via gen_en.

## Structure
- **Package prbs_pkg:** chk_state_t enum (HUNT, VERIFY, LOCKED) and the default POLY/SEED constants.
- **Sub-module lfsr_adv** (combinational; parameters LFSR_W, POLY, DATA_W):
  - Inputs: state.
  - Outputs: next state after DATA_W steps, and the DATA_W output bits.
  - Instantiated twice: generator and checker expected-data path.
- Popcount and saturating add live in prbs_gen_chk.

## Test plan
- **Reset sequence:** defaults, DATA_W=1, gen_en=1 from reset → gen_data is 0 for 24 beats, then 1 on beat 25.
- **Wide beat:** DATA_W=8, gen_en=1 → beats 0-2 = 8'h00 and beat 3 bit 0 = 1. Then seed_load with seed_val=0 → sequence restarts identical to reset, and gen_valid=0 in the load cycle.
- **Loopback lock:** DATA_W=8, gen_data/gen_valid looped to chk_data/chk_valid.
  - chk_state goes HUNT for 4 beats, then VERIFY for 4 beats.
  - chk_locked=1 after the 8th valid beat; err_cnt=0.
- **Error injection while LOCKED:**
  - Flip 2 bits in one beat → err_cnt=2, remains LOCKED.
  - 3 consecutive corrupted beats → HUNT, chk_locked=0, then relocks after 8 more clean beats.
- **Saturation and clear:** CNT_W=4, inject 20 single-bit errors at 1 per beat, spaced by clean beats → err_cnt=15. err_cnt_clr coincident with an error beat → err_cnt=0.
- **Reset and gaps:**
  - Assert rst while in VERIFY → immediately HUNT, err_cnt=0, gen LFSR=SEED.
  - chk_valid gaps during HUNT delay lock by exactly the gap length.
